// File: rtl/sr_flag_pkg.sv
// rtl/sr_flag_pkg.sv - shared constants and helpers for the set/reset flag bank
package sr_flag_pkg;

    localparam int PRIO_CLR = 0;
    localparam int PRIO_SET = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sr_flag_cell.sv
// rtl/sr_flag_cell.sv - one flag channel: sticky flag, overrun and set-edge detect
module sr_flag_cell
    import sr_flag_pkg::*;
#(
    parameter int SET_DOM  = 0,
    parameter int EDGE_SET = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic clr,
    input  logic w1c,
    output logic flag,
    output logic ovr
);

    localparam logic DOM_VAL = (SET_DOM == PRIO_SET);

    logic set_q;
    logic armed;
    logic set_ev;
    logic clr_ev;

    // armed records that set was seen low since reset, so a level held
    // through reset never counts as a rising edge.
    always_comb begin
        set_ev = (EDGE_SET != 0) ? (set & ~set_q & armed) : set;
        clr_ev = clr | w1c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag  <= 1'b0;
            ovr   <= 1'b0;
            set_q <= 1'b0;
            armed <= 1'b0;
        end else begin
            set_q <= set;
            armed <= armed | ~set;

            if (set_ev && clr_ev) begin
                flag <= DOM_VAL;
            end else if (set_ev) begin
                flag <= 1'b1;
            end else if (clr_ev) begin
                flag <= 1'b0;
            end

            // Software clear beats a same-cycle overrun.
            if (w1c) begin
                ovr <= 1'b0;
            end else if (set_ev && flag && !clr_ev) begin
                ovr <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sr_flag_bank.sv
// rtl/sr_flag_bank.sv - bank of independent set/reset flags with mask, count and irq
module sr_flag_bank
    import sr_flag_pkg::*;
#(
    parameter int NCH      = 8,
    parameter int SET_DOM  = 0,
    parameter int EDGE_SET = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NCH-1:0]            set,
    input  logic [NCH-1:0]            clr,
    input  logic                      w1c_en,
    input  logic [NCH-1:0]            w1c_data,
    input  logic                      mask_we,
    input  logic [NCH-1:0]            mask_data,
    output logic [NCH-1:0]            flags,
    output logic [NCH-1:0]            ovr,
    output logic [NCH-1:0]            mask,
    output logic [clog2(NCH+1)-1:0]   cnt,
    output logic                      irq
);

    localparam int CW = clog2(NCH + 1);

    logic [NCH-1:0] w1c_vec;

    assign w1c_vec = w1c_data & {NCH{w1c_en}};

    for (genvar i = 0; i < NCH; i++) begin : g_cell
        sr_flag_cell #(
            .SET_DOM  (SET_DOM),
            .EDGE_SET (EDGE_SET)
        ) u_cell (
            .clk  (clk),
            .rst  (rst),
            .set  (set[i]),
            .clr  (clr[i]),
            .w1c  (w1c_vec[i]),
            .flag (flags[i]),
            .ovr  (ovr[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask <= '0;
            irq  <= 1'b0;
        end else begin
            if (mask_we) begin
                mask <= mask_data;
            end
            irq <= |(flags & mask);
        end
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt = cnt + CW'(flags[i]);
        end
    end

endmodule

// File: tb/tb_sr_flag_bank.sv
// tb/tb_sr_flag_bank.sv - checks clear-dominant, set-dominant and edge-set banks against a reference
module tb_sr_flag_bank;

    logic       clk;
    logic       rst;
    logic [7:0] set;
    logic [7:0] clr;
    logic       w1c_en;
    logic [7:0] w1c_data;
    logic       mask_we;
    logic [7:0] mask_data;

    logic [7:0] fl0, ov0, mk0, fl1, ov1, mk1, fl2, ov2, mk2;
    logic [3:0] c0, c1, c2;
    logic       i0, i1, i2;

    logic [7:0] dfl[3];
    logic [7:0] dov[3];
    logic [7:0] dmk[3];
    logic [3:0] dcn[3];
    logic       dir[3];

    int checks   = 0;
    int failures = 0;

    sr_flag_bank #(.NCH(8), .SET_DOM(0), .EDGE_SET(0)) u_d0 (
        .clk(clk), .rst(rst), .set(set), .clr(clr), .w1c_en(w1c_en), .w1c_data(w1c_data),
        .mask_we(mask_we), .mask_data(mask_data), .flags(fl0), .ovr(ov0), .mask(mk0),
        .cnt(c0), .irq(i0));
    sr_flag_bank #(.NCH(8), .SET_DOM(1), .EDGE_SET(0)) u_d1 (
        .clk(clk), .rst(rst), .set(set), .clr(clr), .w1c_en(w1c_en), .w1c_data(w1c_data),
        .mask_we(mask_we), .mask_data(mask_data), .flags(fl1), .ovr(ov1), .mask(mk1),
        .cnt(c1), .irq(i1));
    sr_flag_bank #(.NCH(8), .SET_DOM(0), .EDGE_SET(1)) u_d2 (
        .clk(clk), .rst(rst), .set(set), .clr(clr), .w1c_en(w1c_en), .w1c_data(w1c_data),
        .mask_we(mask_we), .mask_data(mask_data), .flags(fl2), .ovr(ov2), .mask(mk2),
        .cnt(c2), .irq(i2));

    assign dfl[0] = fl0; assign dov[0] = ov0; assign dmk[0] = mk0; assign dcn[0] = c0; assign dir[0] = i0;
    assign dfl[1] = fl1; assign dov[1] = ov1; assign dmk[1] = mk1; assign dcn[1] = c1; assign dir[1] = i1;
    assign dfl[2] = fl2; assign dov[2] = ov2; assign dmk[2] = mk2; assign dcn[2] = c2; assign dir[2] = i2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: per variant, flag/ovr/mask/irq plus last set value and
    // whether set has been seen low since reset (edge variant only).
    logic [7:0] mf[3];
    logic [7:0] mo[3];
    logic [7:0] mm[3];
    logic [7:0] mp[3];
    logic [7:0] ma[3];
    logic       mi[3];

    function automatic bit set_dom_of(input int v);
        return (v == 1);
    endfunction

    function automatic bit edge_of(input int v);
        return (v == 2);
    endfunction

    function automatic bit set_event(input int v, input int i);
        if (edge_of(v))
            return set[i] && !mp[v][i] && ma[v][i];
        return set[i];
    endfunction

    function automatic logic [7:0] next_flags(input int v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            bit s;
            bit c;
            s = set_event(v, i);
            c = clr[i] || (w1c_en && w1c_data[i]);
            if (s && c)      r[i] = set_dom_of(v);
            else if (s)      r[i] = 1'b1;
            else if (c)      r[i] = 1'b0;
            else             r[i] = mf[v][i];
        end
        return r;
    endfunction

    function automatic logic [7:0] next_ovr(input int v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            bit s;
            bit c;
            s = set_event(v, i);
            c = clr[i] || (w1c_en && w1c_data[i]);
            if (w1c_en && w1c_data[i])   r[i] = 1'b0;
            else if (s && mf[v][i] && !c) r[i] = 1'b1;
            else                          r[i] = mo[v][i];
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < 3; v++) begin
                mf[v] <= '0; mo[v] <= '0; mm[v] <= '0; mp[v] <= '0; ma[v] <= '0; mi[v] <= 1'b0;
            end
        end else begin
            for (int v = 0; v < 3; v++) begin
                mf[v] <= next_flags(v);
                mo[v] <= next_ovr(v);
                mi[v] <= |(mf[v] & mm[v]);
                if (mask_we) mm[v] <= mask_data;
                mp[v] <= set;
                ma[v] <= ma[v] | ~set;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int v = 0; v < 3; v++) begin
                chk($sformatf("v%0d flags", v), int'(dfl[v]), int'(mf[v]));
                chk($sformatf("v%0d ovr", v),   int'(dov[v]), int'(mo[v]));
                chk($sformatf("v%0d mask", v),  int'(dmk[v]), int'(mm[v]));
                chk($sformatf("v%0d cnt", v),   int'(dcn[v]), $countones(mf[v]));
                chk($sformatf("v%0d irq", v),   int'(dir[v]), int'(mi[v]));
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        set = '0; clr = '0; w1c_en = 1'b0; w1c_data = '0; mask_we = 1'b0; mask_data = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        step();
        step();
        chk("reset flags", int'(fl0), 0);
        chk("reset cnt", int'(c0), 0);
        chk("reset irq", int'(i0), 0);
        rst = 1'b0;

        // set pattern 0x05 with mask 0x04
        mask_we = 1'b1; mask_data = 8'h04; step();
        mask_we = 1'b0; set = 8'h05; step();
        set = '0;
        chk("d033 flags", int'(fl0), 8'h05);
        chk("d033 cnt", int'(c0), 2);
        chk("d033 irq early", int'(i0), 0);
        step();
        chk("d033 irq", int'(i0), 1);

        // overrun then w1c
        w1c_en = 1'b1; w1c_data = 8'hFF; step();
        w1c_en = 1'b0; set = 8'h01; step();
        step();
        set = '0;
        chk("d034 flags", int'(fl0), 8'h01);
        chk("d034 ovr", int'(ov0), 8'h01);
        chk("d034 edge ovr", int'(ov2), 8'h00);
        w1c_en = 1'b1; w1c_data = 8'h01; step();
        w1c_en = 1'b0;
        chk("d034 w1c flags", int'(fl0), 8'h00);
        chk("d034 w1c ovr", int'(ov0), 8'h00);

        // set/clr conflict
        set = 8'h80; clr = 8'h80; step();
        set = '0; clr = '0;
        chk("d035 clr dom", int'(fl0[7]), 0);
        chk("d035 set dom", int'(fl1[7]), 1);
        clr = 8'hFF; step();
        clr = '0;

        // held level on the edge-set bank
        set = 8'h08; step();
        chk("d036 first", int'(fl2), 8'h08);
        for (int k = 0; k < 9; k++) step();
        chk("d036 held flags", int'(fl2), 8'h08);
        chk("d036 held ovr", int'(ov2), 8'h00);
        clr = 8'h08; step();
        clr = '0;
        chk("d036 clr", int'(fl2), 8'h00);
        step(); step();
        chk("d036 stays", int'(fl2), 8'h00);
        set = '0; step();

        // mask removed, irq follows a cycle later
        clr = 8'hFF; step();
        clr = '0; set = 8'h10; mask_we = 1'b1; mask_data = 8'h10; step();
        set = '0; mask_we = 1'b0; step();
        chk("d038 irq on", int'(i0), 1);
        mask_we = 1'b1; mask_data = 8'h00; step();
        mask_we = 1'b0;
        chk("d038 mask", int'(mk0), 0);
        chk("d038 irq hold", int'(i0), 1);
        step();
        chk("d038 irq off", int'(i0), 0);
        chk("d038 flags", int'(fl0), 8'h10);

        // async reset mid-cycle, set held across it
        set = 8'hFF; mask_we = 1'b1; mask_data = 8'hFF; step();
        mask_we = 1'b0; step();
        chk("d037 irq pre", int'(i0), 1);
        chk("d037 cnt pre", int'(c0), 8);
        #2 rst = 1'b1;
        #1;
        chk("d037 flags", int'(fl0), 0);
        chk("d037 ovr", int'(ov0), 0);
        chk("d037 mask", int'(mk0), 0);
        chk("d037 cnt", int'(c0), 0);
        chk("d037 irq", int'(i0), 0);
        @(negedge clk); #1;
        rst = 1'b0;
        step();
        chk("d029 level", int'(fl0), 8'hFF);
        chk("d029 held edge", int'(fl2), 8'h00);
        set = '0; step();
        set = 8'h01; step();
        chk("d029 rearmed", int'(fl2), 8'h01);
        idle();

        for (int n = 0; n < 800; n++) begin
            @(negedge clk); #1;
            if (rst) rst = 1'b0;
            if ($urandom_range(0, 1) == 0) set = 8'($urandom & $urandom & $urandom);
            clr       = 8'($urandom & $urandom & $urandom);
            w1c_en    = ($urandom_range(0, 3) == 0);
            w1c_data  = 8'($urandom);
            mask_we   = ($urandom_range(0, 7) == 0);
            mask_data = 8'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                #2 rst = 1'b1;
            end
        end
        @(negedge clk); #1;
        rst = 1'b0;
        idle();
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
